// File: rtl/fp16_dot_accum.sv
// Purpose  : accumulates a stream of fp16 products exactly in wide fixed point and emits one
//            fp16 dot-product result (with overflow flag) per vector tagged by s_last.
// Latency  : m_valid rises in the third cycle after the cycle in which s_last is accepted.
// Backpres.: s_ready is high only while accumulating; the result is held until m_ready.
// Ports    : clk/reset (sync, active-low); s_valid/s_data/s_last/s_ready product input;
//            m_valid/m_data/m_ovf/m_ready result output.
module fp16_dot_accum #(
    parameter int ACC_WIDTH = 56,
    parameter int FRAC_BITS = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        m_valid,
    output logic [15:0] m_data,
    output logic        m_ovf,
    input  logic        m_ready
);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_NORM  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [ACC_WIDTH-1:0] ACC_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0] POS_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] NEG_MAX = {1'b1, {(ACC_WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0] SUM_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SUM_MIN = {2'b11, {(ACC_WIDTH-2){1'b0}}, 1'b1};
    // 65520 is the smallest magnitude that rounds past the largest finite fp16 (65504).
    localparam logic [ACC_WIDTH-1:0] OVF_THRESH = ACC_WIDTH'(65520) << FRAC_BITS;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q,   state_d;
    logic [ACC_WIDTH-1:0] acc_q,     acc_d;
    logic [ACC_WIDTH-1:0] conv_q,    conv_d;
    logic                 conv_vld_q, conv_vld_d;
    logic                 nan_q,     nan_d;
    logic                 ovf_q,     ovf_d;
    logic                 m_valid_q, m_valid_d;
    logic [15:0]          m_data_q,  m_data_d;
    logic                 m_ovf_q,   m_ovf_d;

    logic accept;

    assign s_ready = (state_q == ST_ACCUM);
    assign accept  = s_valid && s_ready;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ovf   = m_ovf_q;

    // ------------------------------------------------------------------
    // Stage 1: fp16 -> fixed point, LSB weight 2^-24
    // ------------------------------------------------------------------
    logic                 in_sgn;
    logic [4:0]           in_exp;
    logic [9:0]           in_man;
    logic                 in_nan;
    logic                 in_inf;
    logic [ACC_WIDTH-1:0] in_mag;
    logic [ACC_WIDTH-1:0] in_conv;

    always_comb begin
        in_sgn = s_data[15];
        in_exp = s_data[14:10];
        in_man = s_data[9:0];
        in_nan = (in_exp == 5'd31) && (in_man != 10'd0);
        in_inf = (in_exp == 5'd31) && (in_man == 10'd0);
        // Hidden bit only for normals; subnormals share exponent 1's scale, hence exp-1.
        in_mag = {{(ACC_WIDTH-11){1'b0}}, (in_exp != 5'd0), in_man};
        if (in_exp != 5'd0) begin
            in_mag = in_mag << (in_exp - 5'd1);
        end
        // Negating zero yields zero, so -0 needs no special case.
        in_conv = in_sgn ? (-in_mag) : in_mag;
        if (in_nan) begin
            in_conv = '0;
        end else if (in_inf) begin
            in_conv = in_sgn ? NEG_MAX : POS_MAX;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturating add
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH:0] sum_w;
    logic [ACC_WIDTH-1:0]      acc_sum;
    logic                      sum_sat;

    always_comb begin
        sum_w   = $signed({acc_q[ACC_WIDTH-1], acc_q}) + $signed({conv_q[ACC_WIDTH-1], conv_q});
        sum_sat = 1'b0;
        acc_sum = sum_w[ACC_WIDTH-1:0];
        if (sum_w > SUM_MAX) begin
            acc_sum = POS_MAX;
            sum_sat = 1'b1;
        end else if (sum_w < SUM_MIN) begin
            acc_sum = NEG_MAX;
            sum_sat = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Normalisation of the final accumulator back to fp16
    // ------------------------------------------------------------------
    logic                 acc_neg;
    logic [ACC_WIDTH-1:0] acc_abs;
    logic [10:0]          mant_sh;
    logic [ACC_WIDTH-1:0] rem_bits;
    logic [ACC_WIDTH-1:0] half_bit;
    logic                 round_up;
    logic [11:0]          mant_rnd;
    int                   lead;
    int                   exp_n;
    logic [15:0]          norm_dat;
    logic                 norm_ovf;

    always_comb begin
        acc_neg = acc_q[ACC_WIDTH-1];
        // Saturation keeps acc above the most negative code, so the negation never wraps.
        acc_abs = acc_neg ? (-acc_q) : acc_q;
        lead = 0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (acc_abs[i]) begin
                lead = i;
            end
        end

        mant_sh  = '0;
        rem_bits = '0;
        half_bit = '0;
        round_up = 1'b0;
        mant_rnd = '0;
        exp_n    = 0;
        if (lead >= 10) begin
            mant_sh  = 11'(acc_abs >> (lead - 10));
            rem_bits = acc_abs & ((ACC_ONE << (lead - 10)) - ACC_ONE);
            // With lead==10 nothing is dropped, so there is nothing to round.
            if (lead > 10) begin
                half_bit = ACC_ONE << (lead - 11);
                round_up = (rem_bits > half_bit) || ((rem_bits == half_bit) && mant_sh[0]);
            end
            mant_rnd = {1'b0, mant_sh} + {11'd0, round_up};
            // A carry out of the 11-bit significand leaves mantissa bits zero and bumps exp.
            exp_n    = lead - 9 + (mant_rnd[11] ? 1 : 0);
        end

        norm_dat = 16'h0000;
        norm_ovf = 1'b0;
        if (nan_q) begin
            norm_dat = 16'h7E00;
        end else if (acc_abs == '0) begin
            norm_dat = 16'h0000;
        end else if (acc_abs >= OVF_THRESH) begin
            norm_dat = {acc_neg, 15'h7BFF};
            norm_ovf = 1'b1;
        end else if (lead < 10) begin
            norm_dat = {acc_neg, 5'd0, acc_abs[9:0]};
        end else if (exp_n >= 31) begin
            norm_dat = {acc_neg, 15'h7BFF};
            norm_ovf = 1'b1;
        end else begin
            norm_dat = {acc_neg, exp_n[4:0], mant_rnd[9:0]};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        conv_d     = accept ? in_conv : '0;
        conv_vld_d = accept;
        nan_d      = nan_q | (accept & in_nan);
        ovf_d      = ovf_q | (accept & in_inf);
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_ovf_d    = m_ovf_q;

        if (conv_vld_q) begin
            acc_d = acc_sum;
            ovf_d = ovf_d | sum_sat;
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept && s_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_NORM;
            end
            ST_NORM: begin
                m_valid_d = 1'b1;
                m_data_d  = norm_dat;
                m_ovf_d   = ovf_q | norm_ovf;
                state_d   = ST_OUT;
            end
            default: begin
                if (m_ready) begin
                    m_valid_d  = 1'b0;
                    acc_d      = '0;
                    conv_d     = '0;
                    conv_vld_d = 1'b0;
                    nan_d      = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            conv_q     <= '0;
            conv_vld_q <= 1'b0;
            nan_q      <= 1'b0;
            ovf_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 16'h0000;
            m_ovf_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            conv_q     <= conv_d;
            conv_vld_q <= conv_vld_d;
            nan_q      <= nan_d;
            ovf_q      <= ovf_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_ovf_q    <= m_ovf_d;
        end
    end

endmodule
